// File: rtl/ber_sync_counter_pkg.sv
// Shared types and widths for the BER sync counter.
// Holds the PRBS period default, the FSM state encoding and the counter widths.
// Also provides a saturating increment used by the 64-bit accumulators.
package ber_pkg;

  localparam int PRBS_MAX_CYCLES_DEF = 511;
  localparam int ACC_W               = 64;  // error / total accumulators
  localparam int STB_W               = 32;  // accepted-strobe counter
  localparam int WIN_W               = 10;  // per-window error count and window position

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_COUNT = 2'd2
  } state_e;

  // Add one bit to an accumulator, sticking at all-ones instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_inc(input logic [ACC_W-1:0] acc,
                                               input logic             inc);
    if (inc && (acc != '1)) begin
      return acc + ACC_W'(1);
    end
    return acc;
  endfunction

endpackage

// File: rtl/ber_sync_counter_if.sv
// Symbol-side bundle of the BER sync counter: strobe, run, data bits in; results out.
// master drives the symbol stream and reads results; slave is the counter itself.
// Port names follow the block's external pin names.
interface ber_sync_counter_if
  import ber_pkg::*;
#(
  parameter int NB_LAT = 9
);

  logic              i_run;
  logic              i_strobe;
  logic              i_rx_bit;
  logic              i_ref_bit;
  logic [NB_LAT-1:0] o_lat;
  logic              o_sync_done;
  logic [ACC_W-1:0]  o_accum_err;
  logic [ACC_W-1:0]  o_accum_tot;

  modport master (
    output i_run, i_strobe, i_rx_bit, i_ref_bit,
    input  o_lat, o_sync_done, o_accum_err, o_accum_tot
  );

  modport slave (
    input  i_run, i_strobe, i_rx_bit, i_ref_bit,
    output o_lat, o_sync_done, o_accum_err, o_accum_tot
  );

endinterface

// File: rtl/ber_sync_counter_delay_line.sv
// Reference-bit delay line with a variable tap read.
// Tap 0 is the live input bit; tap k is the bit from k accepted strobes ago.
// Only TAPS-1 bits are stored since tap 0 never needs a register.
module prbs_ref_delay_line #(
  parameter int TAPS  = 511,
  parameter int IDX_W = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en_i,
  input  logic             bit_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             tap_o
);

  logic [TAPS-2:0] sr_q;
  logic [TAPS-1:0] taps_w;

  // Current view of all taps, newest (live input) at index 0.
  assign taps_w = {sr_q, bit_i};
  assign tap_o  = taps_w[idx_i];

  // Shift one position per accepted strobe; the oldest stored bit drops off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else if (shift_en_i) begin
      sr_q <= taps_w[TAPS-2:0];
    end
  end

endmodule

// File: rtl/ber_sync_counter.sv
// Per-branch BER counter: searches all cyclic PRBS latencies, then counts errors at the best one.
// Outputs are registered; they reflect an accepted strobe on the following cycle.
// No backpressure: i_run low or i_strobe low simply freezes all state.
module ber_sync_counter
  import ber_pkg::*;
#(
  parameter int PRBS_MAX_CYCLES = PRBS_MAX_CYCLES_DEF,
  parameter int START_SYN       = 511 * 690,
  parameter int START_CNT       = START_SYN + 511 * 511,
  parameter int NB_LAT          = $clog2(PRBS_MAX_CYCLES)
) (
  input  logic                clk,
  input  logic                i_reset,
  ber_sync_counter_if.slave   bus
);

  // The search covers PRBS_MAX_CYCLES windows of PRBS_MAX_CYCLES bits each.
  if (START_CNT != START_SYN + PRBS_MAX_CYCLES * PRBS_MAX_CYCLES) begin : g_cfg_check
    $error("START_CNT must equal START_SYN + PRBS_MAX_CYCLES squared");
  end

  state_e             state_q, state_d;
  logic [STB_W-1:0]   stb_cnt_q, stb_cnt_d;
  logic [NB_LAT-1:0]  cand_q, cand_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0]   win_err_q, win_err_d;
  logic [WIN_W-1:0]   min_err_q, min_err_d;
  logic [NB_LAT-1:0]  lat_q, lat_d;
  logic [ACC_W-1:0]   err_q, err_d;
  logic [ACC_W-1:0]   tot_q, tot_d;

  logic               acc_stb_w;
  logic [NB_LAT-1:0]  tap_idx_w;
  logic               tap_w;
  logic               mis_w;
  logic [WIN_W-1:0]   win_sum_w;

  assign acc_stb_w = bus.i_strobe & bus.i_run;
  // While searching we probe the candidate; once locked we use the chosen latency.
  assign tap_idx_w = (state_q == ST_COUNT) ? lat_q : cand_q;
  assign mis_w     = tap_w ^ bus.i_rx_bit;
  // Window total including the current strobe's compare.
  assign win_sum_w = win_err_q + WIN_W'(mis_w);

  prbs_ref_delay_line #(
    .TAPS  (PRBS_MAX_CYCLES),
    .IDX_W (NB_LAT)
  ) u_delay (
    .clk        (clk),
    .rst_n      (i_reset),
    .shift_en_i (acc_stb_w),
    .bit_i      (bus.i_ref_bit),
    .idx_i      (tap_idx_w),
    .tap_o      (tap_w)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus window search, minimum tracking and accumulators; all move only on accepted strobes.
  always_comb begin
    state_d   = state_q;
    stb_cnt_d = stb_cnt_q;
    cand_d    = cand_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    min_err_d = min_err_q;
    lat_d     = lat_q;
    err_d     = err_q;
    tot_d     = tot_q;
    if (acc_stb_w) begin
      unique case (state_q)
        ST_IDLE: begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
          if (stb_cnt_d == STB_W'(START_SYN)) begin
            state_d   = ST_SYNC;
            cand_d    = '0;
            win_cnt_d = '0;
            win_err_d = '0;
            min_err_d = '1;
          end
        end
        ST_SYNC: begin
          stb_cnt_d = stb_cnt_q + STB_W'(1);
          if (win_cnt_q == WIN_W'(PRBS_MAX_CYCLES - 1)) begin
            // Window closes: strict less-than keeps the earliest latency on ties.
            if (win_sum_w < min_err_q) begin
              min_err_d = win_sum_w;
              lat_d     = cand_q;
            end
            win_err_d = '0;
            win_cnt_d = '0;
            if (cand_q == NB_LAT'(PRBS_MAX_CYCLES - 1)) begin
              state_d = ST_COUNT;
            end else begin
              cand_d = cand_q + NB_LAT'(1);
            end
          end else begin
            win_err_d = win_sum_w;
            win_cnt_d = win_cnt_q + WIN_W'(1);
          end
        end
        ST_COUNT: begin
          tot_d = sat_inc(tot_q, 1'b1);
          err_d = sat_inc(err_q, mis_w);
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      stb_cnt_q <= '0;
      cand_q    <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      min_err_q <= '1;
      lat_q     <= '0;
      err_q     <= '0;
      tot_q     <= '0;
    end else begin
      stb_cnt_q <= stb_cnt_d;
      cand_q    <= cand_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      min_err_q <= min_err_d;
      lat_q     <= lat_d;
      err_q     <= err_d;
      tot_q     <= tot_d;
    end
  end

  assign bus.o_lat       = lat_q;
  assign bus.o_sync_done = (state_q == ST_COUNT);
  assign bus.o_accum_err = err_q;
  assign bus.o_accum_tot = tot_q;

endmodule

// File: tb/tb_ber_sync_counter.sv
// Randomized bench for ber_sync_counter with a strobe-index reference model.
// Uses a 31-bit PRBS (x^5+x^3+1) so the full search fits in a short run.
module tb_ber_sync_counter;
  import ber_pkg::*;

  localparam int P  = 31;
  localparam int SS = 40;
  localparam int SC = SS + P * P;
  localparam int NL = $clog2(P);
  localparam int FRZ = 200;

  logic clk = 1'b0;
  logic i_reset;
  always #5 clk = ~clk;

  ber_sync_counter_if #(.NB_LAT(NL)) bus();

  ber_sync_counter #(
    .PRBS_MAX_CYCLES (P),
    .START_SYN       (SS),
    .START_CNT       (SC),
    .NB_LAT          (NL)
  ) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Reference model, indexed by accepted-strobe number.
  bit              ref_h [0:4095];
  int              m_n;
  int              win_e [0:P-1];
  int              best_lat;
  int              best_err;
  longint unsigned m_err;
  longint unsigned m_tot;
  logic [4:0]      lfsr;

  function automatic void model_reset();
    m_n = 0;
    foreach (win_e[i]) win_e[i] = 0;
    best_lat = 0;
    best_err = 1 << 30;
    m_err = 0;
    m_tot = 0;
  endfunction

  function automatic bit ref_at(input int idx);
    return (idx >= 0) ? ref_h[idx] : 1'b0;
  endfunction

  function automatic void model_step(input bit rb, input bit xb);
    int l;
    bit mis;
    ref_h[m_n] = rb;
    if (m_n >= SS && m_n < SC) begin
      l = (m_n - SS) / P;
      mis = ref_at(m_n - l) ^ xb;
      win_e[l] += int'(mis);
      if (((m_n - SS) % P) == P - 1 && win_e[l] < best_err) begin
        best_err = win_e[l];
        best_lat = l;
      end
    end else if (m_n >= SC) begin
      mis = ref_at(m_n - best_lat) ^ xb;
      m_err += longint'(mis);
      m_tot++;
    end
    m_n++;
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".lat"},  64'(bus.o_lat),       64'(best_lat));
    chk({tag, ".done"}, 64'(bus.o_sync_done), 64'(m_n >= SC));
    chk({tag, ".err"},  bus.o_accum_err,      m_err);
    chk({tag, ".tot"},  bus.o_accum_tot,      m_tot);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b0;
    bus.i_run = 1'b0; bus.i_strobe = 1'b0; bus.i_rx_bit = 1'b0; bus.i_ref_bit = 1'b0;
    @(negedge clk);
    model_reset();
    lfsr = 5'b00001;
    i_reset = 1'b1;
  endtask

  // rx_mode 0: ref delayed by d; 1: constant 0. flip_mode 0: none; 1: every 10th COUNT bit; 2: random ~3%.
  // stb_mode 0: strobe every 2nd clk; 1: random strobes and random run drops.
  task automatic run_scn(input string tag, input int d, input int rx_mode, input int flip_mode,
                         input int stb_mode, input int freeze_at, input int n_target,
                         output int rise_cyc);
    int cyc = 0;
    int fz_start = -1;
    bit stb, run, rb, xb, acc;
    rise_cyc = -1;
    while (m_n < n_target) begin
      if (cyc >= 20000) begin
        chk({tag, ".timeout"}, 64'(m_n), 64'(n_target));
        break;
      end
      stb = (stb_mode == 0) ? (cyc % 2 == 0) : ($urandom_range(9) < 7);
      run = 1'b1;
      if (freeze_at >= 0 && fz_start < 0 && m_n == freeze_at) fz_start = cyc;
      if (fz_start >= 0 && cyc < fz_start + FRZ) run = 1'b0;
      if (stb_mode == 1 && $urandom_range(9) == 0) run = 1'b0;
      acc = stb && run;
      if (acc) begin
        rb = lfsr[4];
        xb = (rx_mode == 0) ? ref_at(m_n - d) : 1'b0;
        if (flip_mode == 1 && m_n >= SC && ((m_n - SC) % 10) == 9) xb = ~xb;
        if (flip_mode == 2 && $urandom_range(99) < 3) xb = ~xb;
      end else begin
        rb = 1'($urandom_range(1));
        xb = 1'($urandom_range(1));
      end
      bus.i_strobe = stb; bus.i_run = run; bus.i_ref_bit = rb; bus.i_rx_bit = xb;
      @(posedge clk);
      if (acc) begin
        model_step(rb, xb);
        lfsr = {lfsr[3:0], lfsr[4] ^ lfsr[2]};
      end
      @(negedge clk);
      cyc++;
      check_outputs(tag);
      if (bus.o_sync_done && rise_cyc < 0) rise_cyc = cyc;
    end
    bus.i_strobe = 1'b0;
    bus.i_run = 1'b0;
  endtask

  initial begin
    int rise;
    int d;
    i_reset = 1'b0;
    bus.i_run = 1'b0; bus.i_strobe = 1'b0; bus.i_rx_bit = 1'b0; bus.i_ref_bit = 1'b0;
    model_reset();
    lfsr = 5'b00001;

    // Held in reset with toggling inputs, then idle with run low.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bus.i_run = 1'($urandom_range(1)); bus.i_strobe = 1'($urandom_range(1));
      bus.i_rx_bit = 1'($urandom_range(1)); bus.i_ref_bit = 1'($urandom_range(1));
      @(negedge clk);
      check_outputs("rst_hold");
    end
    @(negedge clk);
    i_reset = 1'b1;
    bus.i_run = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.i_strobe = 1'($urandom_range(1));
      bus.i_rx_bit = 1'($urandom_range(1)); bus.i_ref_bit = 1'($urandom_range(1));
      @(negedge clk);
      check_outputs("run_low");
    end

    // Clean channel at delay 13.
    do_reset();
    run_scn("clean", 13, 0, 0, 0, -1, SC + 500, rise);
    chk("clean.lat_final", 64'(bus.o_lat), 64'd13);
    chk("clean.rise_cyc",  64'(rise), 64'(2 * (SC - 1) + 1));
    chk("clean.err_final", bus.o_accum_err, 64'd0);
    chk("clean.tot_final", bus.o_accum_tot, 64'd500);

    // Async reset in the middle of counting, then a full re-search.
    @(negedge clk);
    bus.i_strobe = 1'b1; bus.i_run = 1'b1;
    i_reset = 1'b0;
    #1;
    chk("midrst.lat",  64'(bus.o_lat), 64'd0);
    chk("midrst.done", 64'(bus.o_sync_done), 64'd0);
    chk("midrst.err",  bus.o_accum_err, 64'd0);
    chk("midrst.tot",  bus.o_accum_tot, 64'd0);
    do_reset();
    run_scn("rerun", 13, 0, 0, 0, -1, SC + 50, rise);
    chk("rerun.lat_final", 64'(bus.o_lat), 64'd13);
    chk("rerun.tot_final", bus.o_accum_tot, 64'd50);

    // Every 10th counted bit inverted.
    do_reset();
    run_scn("inject", 13, 0, 1, 0, -1, SC + 500, rise);
    chk("inject.err_final", bus.o_accum_err, 64'd50);
    chk("inject.tot_final", bus.o_accum_tot, 64'd500);

    // Constant-zero rx: all windows tie, earliest latency wins.
    do_reset();
    run_scn("tie", 13, 1, 0, 0, -1, SC + 300, rise);
    chk("tie.lat_final", 64'(bus.o_lat), 64'd0);

    // Run dropped for FRZ clocks mid-search.
    do_reset();
    run_scn("freeze", 13, 0, 0, 0, SS + 100, SC + 20, rise);
    chk("freeze.lat_final", 64'(bus.o_lat), 64'd13);
    chk("freeze.rise_cyc",  64'(rise), 64'(2 * (SC - 1) + 1 + FRZ));

    // Random delay, noisy channel, random/back-to-back strobes and run drops.
    d = $urandom_range(P - 1, 1);
    do_reset();
    run_scn("random", d, 0, 2, 1, -1, SC + 400, rise);
    chk("random.lat_final", 64'(bus.o_lat), 64'(d));
    chk("random.tot_final", bus.o_accum_tot, 64'd400);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ber_sync_counter.md
# ber_sync_counter

Symbol-rate bit-error-rate counter for one QPSK branch (I or Q). It sits downstream of the adaptive-filter slicer, with one instance per branch. It compares the sliced received bit against the local PRBS9 reference bit and searches all cyclic latencies for the best alignment. It then accumulates error and total-bit counts at the chosen latency.

## Interface
- `PRBS_MAX_CYCLES`, default 511: PRBS period; length of the reference delay line; number of candidate latencies and bits per candidate window.
- `START_SYN`, default 511*690: strobe index at which the latency search starts.
- `START_CNT`, default START_SYN+511*511: strobe index at which counting starts. Must equal START_SYN + PRBS_MAX_CYCLES².
- `NB_LAT`, default $clog2(PRBS_MAX_CYCLES): latency width.

Ports:
- `clk`  in  1  system clock.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_run`  in  1  global enable (switch). Low freezes all state.
- `i_strobe`  in  1  symbol strobe, one clk pulse per baud (every OVERSAMP clocks).
- `i_rx_bit`  in  1  sliced received bit (sign of slicer output, 1 = negative).
- `i_ref_bit`  in  1  local PRBS9 bit for this symbol.
- `o_lat`  out  NB_LAT  best latency so far; final once `o_sync_done`=1.
- `o_sync_done`  out  1  high in COUNT state.
- `o_accum_err`  out  64  accumulated bit errors.
- `o_accum_tot`  out  64  accumulated compared bits.

## Operation
- Accepted strobe: `i_strobe`=1 and `i_run`=1. Nothing changes on other cycles.
- Delay line: on each accepted strobe, `i_ref_bit` shifts into tap 0 and tap k moves to k+1, over PRBS_MAX_CYCLES taps. Compared bit = tap[L] XOR `i_rx_bit`, where L is the current candidate (SYNC) or `o_lat` (COUNT).
- Strobe counter: 32 bits. Increments per accepted strobe until COUNT is entered, then holds.
- States:
  - IDLE: shift only. When the counter reaches START_SYN → SYNC with L=0, win_cnt=0, win_err=0, min_err=all-ones (10 bits).
  - SYNC: per accepted strobe, win_err += mismatch and win_cnt++.
    - When win_cnt reaches PRBS_MAX_CYCLES−1, the window closes, with that strobe's mismatch included.
    - On close: if the final win_err < min_err (strict), then min_err←win_err and `o_lat`←L.
    - After the compare: clear win_err/win_cnt, L++.
    - Close with L=PRBS_MAX_CYCLES−1 → COUNT. This must coincide with strobe index START_CNT.
  - COUNT: per accepted strobe, tot += 1 and err += mismatch. Both saturate at 2⁶⁴−1. Terminal; only reset leaves it.
- Tie rule: strict less-than, so the earliest latency with the minimum error count wins.
- win_err is 10 bits (max 511); no overflow is possible.

## Timing
- All outputs are registered and update on the clk edge that samples the accepted strobe, i.e. they are visible the next cycle.
- `o_sync_done` rises on the same edge that closes the last window; `o_lat` is final on that edge.
- The first counted strobe is the one after the transition edge.
- Reset (async, any state, including mid-window or mid-count): state=IDLE; `o_lat`=0, `o_sync_done`=0, `o_accum_err`=0, `o_accum_tot`=0; delay line, strobe counter, win_* and L cleared; min_err=all-ones.
- `i_run` low mid-window: window content is preserved. The final result equals the uninterrupted run, shifted in time.
- `i_strobe` held high for consecutive clocks: each cycle is an accepted strobe. No edge detection.

## Structure
- Shared package `ber_pkg`: PRBS_MAX_CYCLES default, state enum (IDLE/SYNC/COUNT), counter widths (64 accum, 32 strobe, 10 window).
- Sub-module `prbs_ref_delay_line`: parameterised shift register with strobe enable and a variable-index tap read. Keeps the mux off the FSM.
- Top: FSM, window/min logic, accumulators.

## Test plan
- Reset: hold `i_reset`=0, toggle inputs → all outputs 0, and they stay 0 for 100 cycles after release with `i_run`=0.
- Clean channel: rx = ref delayed 37 strobes, strobe every 4 clk, `i_run`=1 → at START_CNT, `o_lat`=37 and `o_sync_done`=1. After 10 000 more strobes, err=0 and tot=10 000.
- Error injection: delay 37, invert every 100th rx bit in COUNT → after 10 000 strobes, err=100 and tot=10 000.
- Tie: rx constant 0 → every window has 256 errors, so `o_lat`=0 and err increments on every reference-1 bit.
- Freeze: drop `i_run` for 1000 clk mid-SYNC → same `o_lat` as the clean run; `o_sync_done` delayed by exactly 1000 clk.
- Reset mid-COUNT: assert `i_reset` during counting → outputs 0 asynchronously (before the next clk edge), state IDLE, and the full search re-runs to the same `o_lat`.
